crypto_barrett_reduce_26_12: RTL and testbench
==============================================

// Module: crypto_barrett_reduce_26_12
// PURPOSE
//  Pipelined Barrett reducer directly downstream of the 14x12-bit unsigned coefficient
//  multiplier. Takes each 26-bit product and returns x mod Q as a 12-bit residue.
//  Uses a valid/ready stream with full backpressure.
//  Frames results into polynomials of N_COEF coefficients by asserting dout_last on every
//  N_COEF-th accepted output.
// PARAMETERS
//  DIN_W   26     product width; also Barrett shift K
//  DOUT_W  12     residue width; requires Q < 2**DOUT_W
//  Q       3329   modulus
//  M       20158  floor(2**DIN_W / Q); must match Q/DIN_W
//  N_COEF  256    coefficients per polynomial (dout_last period)
// PORTS
//  ap_clk      in   1       clock, rising edge
//  ap_rst_n    in   1       asynchronous active-low reset
//  din         in   DIN_W   unsigned product from multiplier
//  din_valid   in   1       din valid
//  din_ready   out  1       stage can accept din this cycle
//  dout        out  DOUT_W  residue, 0 <= dout < Q
//  dout_valid  out  1       dout valid
//  dout_ready  in   1       consumer accepts dout this cycle
//  dout_last   out  1       dout is the final coefficient of a polynomial
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valids=0, dout=0, dout_last=0,
//    coefficient counter=0. Since dout_valid=0, din_ready=1 in reset.
//  - Transfer rule: a transfer occurs when valid&ready are both 1 on a rising edge.
//  - Pipeline: 3 register stages, global advance enable
//    adv = !dout_valid | dout_ready. din_ready = adv (combinational).
//  - S1: p1 = din * M, full (DIN_W+15)-bit product; x1 = din; v1 = din_valid.
//  - S2: t = p1 >> DIN_W; r2 = x1 - t*Q, kept at DOUT_W+1 bits; v2 = v1.
//  - S3: dout = (r2 >= Q) ? r2 - Q : r2; dout_valid = v2.
//  - Math bound: for x < 2**DIN_W, floor(x/Q)-1 <= t <= floor(x/Q), so 0 <= r2 < 2Q.
//    A single conditional subtract is exact. No negative intermediate ever occurs.
//  - Latency: exactly 3 cycles from din transfer to dout_valid when there are no stalls.
//    Throughput is 1 per cycle.
//  - Stall: when adv=0, every stage register holds, including dout and dout_last.
//    dout/dout_valid/dout_last stay stable until dout_ready=1.
//  - Bubbles (din_valid=0 while adv=1) propagate as invalid slots. Data in invalid
//    slots is don't-care, but dout must not change while dout_valid=1 and stalled.
//  - Counter: cnt in 0..N_COEF-1 is loaded at S3 alongside the data.
//    dout_last = (cnt == N_COEF-1) for the entry being loaded.
//    cnt increments on each valid entry into S3 and wraps N_COEF-1 -> 0.
//    cnt is never affected by bubbles or stalls.
//  - Reset mid-stream: in-flight results are discarded and the counter restarts at 0.
//    The next output after reset is coefficient 0.
//  - No X propagation: the datapath updates only when adv=1.
// TESTING
//  1. Reset then din=0, 3328, 3329, 6658 on consecutive cycles, dout_ready=1
//     -> dout 0, 3328, 0, 0 on cycles 3..6, din_ready held at 1.
//  2. din=67108863 -> 2881; din=67088385 (16383*4095) -> 2377
//     -> checks the upper input boundary.
//  3. Random 10k din < 2**26 with random din_valid/dout_ready
//     -> dout == din % 3329 in order, no loss or duplication.
//     -> dout stable whenever dout_valid & !dout_ready.
//  4. Backpressure: fill the pipe, hold dout_ready=0 for 5 cycles
//     -> din_ready=0 throughout, dout unchanged.
//     -> on release, the 3 stored results drain in order.
//  5. Stream 512 valid inputs with bubbles
//     -> dout_last high only on outputs #255 and #511 (0-based), low otherwise.
//  6. Assert ap_rst_n=0 mid-stream, after 100 outputs, asynchronously between edges
//     -> dout_valid=0 immediately.
//     -> after release, the next 256th output is the first with dout_last=1.

Source files
------------

// File: rtl/crypto_barrett_reduce_26_12.sv
// Three-stage Barrett reducer: 26-bit product in, residue mod Q out, with framing of N_COEF coefficients.
// Latency 3 cycles, 1/cycle; a single advance enable freezes every stage while the output is held.
module crypto_barrett_reduce_26_12 #(
  parameter int unsigned DIN_W  = 26,
  parameter int unsigned DOUT_W = 12,
  parameter int unsigned Q      = 3329,
  parameter int unsigned M      = 20158,
  parameter int unsigned N_COEF = 256
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [DIN_W-1:0]  din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last
);

  localparam int unsigned M_W   = 15;
  localparam int unsigned P_W   = DIN_W + M_W;
  localparam int unsigned T_W   = P_W - DIN_W;
  localparam int unsigned R_W   = DOUT_W + 1;
  localparam int unsigned CNT_W = (N_COEF > 1) ? $clog2(N_COEF) : 1;

  localparam logic [M_W-1:0]    M_C      = M_W'(M);
  localparam logic [R_W-1:0]    Q_R      = R_W'(Q);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_COEF - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  if (M != ((64'd1 << DIN_W) / Q)) begin : g_bad_m
    $error("M must equal floor(2**DIN_W / Q)");
  end
  if (Q >= (64'd1 << DOUT_W)) begin : g_bad_q
    $error("Q must fit in DOUT_W bits");
  end

  // Stage registers
  logic [P_W-1:0]    p1_q, p1_d;
  logic [R_W-1:0]    x1_q, x1_d;
  logic              v1_q;
  logic [R_W-1:0]    r2_q, r2_d;
  logic              v2_q;
  logic [DOUT_W-1:0] dout_q, dout_d;
  logic              dout_valid_q;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              adv;
  logic [T_W-1:0]    t;
  logic [DIN_W-1:0]  p1_lo_unused;
  logic [R_W-1:0]    tq;

  assign adv       = !dout_valid_q || dout_ready;
  assign din_ready = adv;

  // S1: quotient estimate product; only the low R_W bits of x matter since 0 <= x - t*Q < 2Q.
  assign p1_d = P_W'(din) * P_W'(M_C);
  assign x1_d = din[R_W-1:0];

  // S2: arithmetic modulo 2**R_W is exact because the true remainder lies in [0, 2Q).
  assign {t, p1_lo_unused} = p1_q;
  assign tq   = R_W'(t) * Q_R;
  assign r2_d = x1_q - tq;

  // S3: final correction and framing counter.
  always_comb begin
    dout_d = r2_q[DOUT_W-1:0];
    if (r2_q >= Q_R) begin
      dout_d = DOUT_W'(r2_q - Q_R);
    end
    last_d = v2_q && (cnt_q == CNT_LAST);
    cnt_d  = cnt_q;
    if (v2_q) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      p1_q         <= '0;
      x1_q         <= '0;
      v1_q         <= 1'b0;
      r2_q         <= '0;
      v2_q         <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
    end else if (adv) begin
      p1_q         <= p1_d;
      x1_q         <= x1_d;
      v1_q         <= din_valid;
      r2_q         <= r2_d;
      v2_q         <= v1_q;
      dout_q       <= dout_d;
      dout_valid_q <= v2_q;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_last  = last_q;

endmodule

// File: tb/tb_crypto_barrett_reduce_26_12.sv
// Scoreboard bench for the Barrett reducer: residues, latency, backpressure, framing, reset.
module tb_crypto_barrett_reduce_26_12;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [25:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [11:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        dout_last;

  crypto_barrett_reduce_26_12 dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last)
  );

  always #5 ap_clk = ~ap_clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned exp_q[$];
  int          out_cnt = 0;

  logic        in_fire, out_fire, rdy_s, vld_s, last_s;
  logic [11:0] dout_s;

  // One clock: drive inputs, sample handshake mid-cycle, push accepted inputs to the scoreboard.
  task automatic cycle(input logic [25:0] d, input logic dv, input logic dr);
    din        = d;
    din_valid  = dv;
    dout_ready = dr;
    #1;
    rdy_s    = din_ready;
    vld_s    = dout_valid;
    dout_s   = dout;
    last_s   = dout_last;
    in_fire  = dv && din_ready;
    out_fire = dout_valid && dr;
    if (in_fire) exp_q.push_back(int'(d) % 3329);
    @(posedge ap_clk);
    #1;
  endtask

  task automatic test_reset();
    ap_rst_n   = 1'b0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    #1;
    n_checks++;
    if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
    n_checks++;
    if (din_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", din_ready); end
    n_checks++;
    if (dout !== 12'd0) begin n_fail++; $display("FAIL reset_dout: got %0d want 0", dout); end
    n_checks++;
    if (dout_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", dout_last); end
    @(posedge ap_clk);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    exp_q.delete();
    out_cnt = 0;
  endtask

  task automatic test_basic();
    logic [25:0] vals [4];
    int unsigned e;
    vals = '{26'd0, 26'd3328, 26'd3329, 26'd6658};
    for (int i = 0; i < 8; i++) begin
      cycle((i < 4) ? vals[i] : 26'd0, (i < 4), 1'b1);
      if (i < 4) begin
        n_checks++;
        if (rdy_s !== 1'b1) begin n_fail++; $display("FAIL basic_ready[%0d]: got %b want 1", i, rdy_s); end
      end
      n_checks++;
      if (out_fire !== (i >= 3 && i <= 6)) begin
        n_fail++; $display("FAIL basic_latency[%0d]: dout_valid got %b want %b", i, out_fire, (i >= 3 && i <= 6));
      end
      if (out_fire) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL basic_extra: got %0d, nothing expected", dout_s); end
        else begin
          e = exp_q.pop_front();
          if (dout_s !== e[11:0]) begin n_fail++; $display("FAIL basic_dout[%0d]: got %0d want %0d", i, dout_s, e); end
        end
        n_checks++;
        if (last_s !== (out_cnt % 256 == 255)) begin n_fail++; $display("FAIL basic_last: got %b", last_s); end
        out_cnt++;
      end
    end
  endtask

  task automatic test_boundary();
    logic [25:0] vals [2];
    logic [11:0] want [2];
    int unsigned e;
    int k = 0;
    vals = '{26'd67108863, 26'd67088385};
    want = '{12'd2881, 12'd2377};
    for (int i = 0; i < 12 && k < 2; i++) begin
      cycle((i < 2) ? vals[i] : 26'd0, (i < 2), 1'b1);
      if (out_fire) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL bound_extra: got %0d", dout_s); end
        else begin
          e = exp_q.pop_front();
          if (dout_s !== e[11:0] || dout_s !== want[k]) begin
            n_fail++; $display("FAIL bound_dout[%0d]: got %0d want %0d", k, dout_s, want[k]);
          end
        end
        n_checks++;
        if (last_s !== (out_cnt % 256 == 255)) begin n_fail++; $display("FAIL bound_last: got %b", last_s); end
        out_cnt++;
        k++;
      end
    end
    n_checks++;
    if (k != 2) begin n_fail++; $display("FAIL bound_count: got %0d outputs want 2", k); end
  endtask

  task automatic test_random();
    int acc = 0;
    int cyc = 0;
    int unsigned e;
    logic dv, dr, prev_stall;
    logic [11:0] prev_d;
    logic prev_last;
    logic [25:0] d;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_last = 1'b0;
    while ((acc < 10000 || exp_q.size() > 0) && cyc < 40000) begin
      dv = (acc < 10000) && ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 15))
        0:       d = 26'h3FFFFFF;
        1:       d = 26'(3329 * $urandom_range(0, 20158));
        default: d = 26'($urandom);
      endcase
      cycle(d, dv, dr);
      cyc++;
      if (in_fire) acc++;
      if (prev_stall) begin
        n_checks++;
        if (vld_s !== 1'b1 || dout_s !== prev_d || last_s !== prev_last) begin
          n_fail++; $display("FAIL rand_stable: valid %b dout %0d last %b want 1 %0d %b", vld_s, dout_s, last_s, prev_d, prev_last);
        end
      end
      prev_stall = vld_s && !dr;
      prev_d = dout_s;
      prev_last = last_s;
      if (out_fire) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rand_dup: got %0d, nothing expected", dout_s); end
        else begin
          e = exp_q.pop_front();
          if (dout_s !== e[11:0]) begin n_fail++; $display("FAIL rand_dout: got %0d want %0d", dout_s, e); end
        end
        n_checks++;
        if (last_s !== (out_cnt % 256 == 255)) begin n_fail++; $display("FAIL rand_last: got %b at output %0d", last_s, out_cnt); end
        out_cnt++;
      end
    end
    n_checks++;
    if (acc != 10000 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_budget: accepted %0d pending %0d want 10000 0", acc, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [25:0] vals [3];
    int unsigned e, held;
    vals = '{26'd100000, 26'd200001, 26'd67108863};
    for (int i = 0; i < 3; i++) begin
      cycle(vals[i], 1'b1, 1'b0);
      n_checks++;
      if (in_fire !== 1'b1) begin n_fail++; $display("FAIL bp_fill[%0d]: accept got %b want 1", i, in_fire); end
    end
    held = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      cycle(26'd5, 1'b1, 1'b0);
      n_checks++;
      if (rdy_s !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", i, rdy_s); end
      n_checks++;
      if (vld_s !== 1'b1 || dout_s !== held[11:0]) begin
        n_fail++; $display("FAIL bp_hold[%0d]: valid %b dout %0d want 1 %0d", i, vld_s, dout_s, held);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(26'd0, 1'b0, 1'b1);
      n_checks++;
      if (out_fire !== 1'b1) begin n_fail++; $display("FAIL bp_drain_valid[%0d]: got %b want 1", i, out_fire); end
      else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (dout_s !== e[11:0]) begin n_fail++; $display("FAIL bp_drain[%0d]: got %0d want %0d", i, dout_s, e); end
        n_checks++;
        if (last_s !== (out_cnt % 256 == 255)) begin n_fail++; $display("FAIL bp_last: got %b", last_s); end
        out_cnt++;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_leftover: got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_framing();
    int sent = 0;
    int cyc = 0;
    int lasts = 0;
    int unsigned e;
    logic dv;
    test_reset();
    while ((sent < 512 || exp_q.size() > 0) && cyc < 3000) begin
      dv = (sent < 512) && ($urandom_range(0, 3) != 0);
      cycle(26'($urandom), dv, ($urandom_range(0, 4) != 0));
      cyc++;
      if (in_fire) sent++;
      if (out_fire) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL frame_extra: got %0d", dout_s); end
        else begin
          e = exp_q.pop_front();
          if (dout_s !== e[11:0]) begin n_fail++; $display("FAIL frame_dout: got %0d want %0d", dout_s, e); end
        end
        n_checks++;
        if (last_s !== (out_cnt == 255 || out_cnt == 511)) begin
          n_fail++; $display("FAIL frame_last: output %0d got %b", out_cnt, last_s);
        end
        if (last_s) lasts++;
        out_cnt++;
      end
    end
    n_checks++;
    if (lasts != 2 || out_cnt != 512) begin
      n_fail++; $display("FAIL frame_count: lasts %0d outputs %0d want 2 512", lasts, out_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int outs = 0;
    int cyc = 0;
    int sent = 0;
    int first_last = -1;
    int unsigned e;
    while (outs < 100 && cyc < 500) begin
      cycle(26'($urandom), 1'b1, 1'b1);
      cyc++;
      if (out_fire) begin
        outs++;
        exp_q.pop_front();
        out_cnt++;
      end
    end
    n_checks++;
    if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL mid_prevalid: got %b want 1", dout_valid); end
    #2;
    ap_rst_n = 1'b0;
    din_valid = 1'b0;
    #1;
    n_checks++;
    if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async: dout_valid got %b want 0", dout_valid); end
    exp_q.delete();
    out_cnt = 0;
    @(posedge ap_clk);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    cyc = 0;
    while ((sent < 300 || exp_q.size() > 0) && cyc < 2000) begin
      cycle(26'($urandom), (sent < 300) && ($urandom_range(0, 5) != 0), 1'b1);
      cyc++;
      if (in_fire) sent++;
      if (out_fire) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL mid_extra: got %0d", dout_s); end
        else begin
          e = exp_q.pop_front();
          if (dout_s !== e[11:0]) begin n_fail++; $display("FAIL mid_dout: got %0d want %0d", dout_s, e); end
        end
        if (last_s && first_last < 0) first_last = out_cnt;
        out_cnt++;
      end
    end
    n_checks++;
    if (first_last != 255) begin n_fail++; $display("FAIL mid_first_last: got %0d want 255", first_last); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_random();
    test_backpressure();
    test_framing();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
